// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, byte-enable
// patterns and the store-side lane helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [3:0] byte_enables(input lsu_size_e size, input logic [1:0] off);
        case (size)
            BYTE:    byte_enables = BE_BYTE << off;
            HALF:    byte_enables = BE_HALF << {off[1], 1'b0};
            default: byte_enables = BE_WORD;
        endcase
    endfunction

    // Stores drive every lane with the datum so memory only needs the byte enables.
    function automatic logic [31:0] replicate(input lsu_size_e size, input logic [31:0] d);
        case (size)
            BYTE:    replicate = {4{d[7:0]}};
            HALF:    replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (off)
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            2'd3:    lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];

        case (size)
            BYTE:    result = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            HALF:    result = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory load/store unit: IDLE -> REQ -> DONE with a
// bounded wait for mem_ack and a one-cycle misalign/bus-error pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_rd_e,
    input  logic        d_wr_e,
    input  logic        sb,
    input  logic        sh,
    input  logic        sw,
    input  logic        lb,
    input  logic        lh,
    input  logic        lw,
    input  logic        lbu,
    input  logic        lhu,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // The wait ends on the REQ cycle where the counter would step onto TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state;
    logic [7:0]  wait_cnt;
    lsu_size_e   ld_size;
    logic        ld_unsigned;
    logic [1:0]  ld_off;

    lsu_size_e   size_sel;
    logic        unsigned_sel;
    logic        req_in;
    logic        unaligned;
    logic        accept;
    logic [31:0] load_result;

    // Writes win over reads; within a direction, word beats half beats byte.
    always_comb begin
        size_sel     = WORD;
        unsigned_sel = 1'b0;
        if (d_wr_e) begin
            if (sw)      size_sel = WORD;
            else if (sh) size_sel = HALF;
            else if (sb) size_sel = BYTE;
        end else begin
            if (lw) begin
                size_sel = WORD;
            end else if (lh | lhu) begin
                size_sel     = HALF;
                unsigned_sel = lhu & ~lh;
            end else if (lb | lbu) begin
                size_sel     = BYTE;
                unsigned_sel = lbu & ~lb;
            end
        end
    end

    assign req_in    = d_rd_e | d_wr_e;
    assign unaligned = ((lh | lhu | sh) & addr[0]) | ((lw | sw) & (addr[1:0] != 2'b00));
    assign accept    = (state == IDLE) & req_in & ~unaligned;
    assign stall     = rst_n & (accept | (state == REQ));

    lsu_load_align u_load_align (
        .word        (mem_rdata),
        .off         (ld_off),
        .size        (ld_size),
        .is_unsigned (ld_unsigned),
        .result      (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            rdata       <= 32'd0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            ld_size     <= WORD;
            ld_unsigned <= 1'b0;
            ld_off      <= 2'b00;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_in && unaligned) begin
                        misalign <= 1'b1;
                        rdata    <= 32'd0;
                    end else if (accept) begin
                        state       <= REQ;
                        wait_cnt    <= 8'd0;
                        mem_req     <= 1'b1;
                        mem_we      <= d_wr_e;
                        mem_addr    <= {addr[31:2], 2'b00};
                        mem_be      <= byte_enables(size_sel, addr[1:0]);
                        mem_wdata   <= replicate(size_sel, wdata);
                        ld_size     <= size_sel;
                        ld_unsigned <= unsigned_sel;
                        ld_off      <= addr[1:0];
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) rdata <= load_result;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == CNT_LAST) begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                            bus_err <= 1'b1;
                            rdata   <= 32'd0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares whenever the DUT presents one.
module tb_load_store_unit;

    localparam int W = 80;
    localparam logic [3:0] EV_REQ = 4'd1;
    localparam logic [3:0] EV_END = 4'd2;
    localparam logic [3:0] EV_MIS = 4'd3;

    logic        clk;
    logic        rst_n;
    logic        d_rd_e, d_wr_e;
    logic        sb, sh, sw, lb, lh, lw, lbu, lhu;
    logic [31:0] addr, wdata, rdata;
    logic        stall, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .d_rd_e(d_rd_e), .d_wr_e(d_wr_e),
        .sb(sb), .sh(sh), .sw(sw), .lb(lb), .lh(lh), .lw(lw), .lbu(lbu), .lhu(lhu),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    function automatic void push_req(input logic we, input logic [3:0] be,
                                     input logic [31:0] a, input logic [31:0] wd);
        exp_q.push_back({EV_REQ, 7'd0, we, be, a, wd});
    endfunction

    function automatic void push_end(input logic berr, input logic [7:0] stall_cycles,
                                     input logic [31:0] rd);
        exp_q.push_back({EV_END, 35'd0, berr, stall_cycles, rd});
    endfunction

    function automatic void push_mis(input logic [31:0] rd);
        exp_q.push_back({EV_MIS, 42'd0, 1'b0, 1'b0, rd});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic sb_compare(input logic [W-1:0] act);
        logic [W-1:0] exp;
        string name;
        case (act[W-1:W-4])
            EV_REQ:  name = "req_fields";
            EV_END:  name = "access_end";
            default: name = "misalign_pulse";
        endcase
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected event got=%h exp=<none>", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s got=%h exp=%h", name, act, exp);
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_stall = 1'b0;
    logic       prev_req = 1'b0;
    logic [7:0] stall_run = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
            stall_run  = 8'd0;
        end else begin
            if (mem_req && !prev_req)
                sb_compare({EV_REQ, 7'd0, mem_we, mem_be, mem_addr, mem_wdata});
            if (!stall && prev_stall)
                sb_compare({EV_END, 35'd0, bus_err, stall_run, rdata});
            if (misalign)
                sb_compare({EV_MIS, 42'd0, mem_req, stall, rdata});
            stall_run  = stall ? stall_run + 8'd1 : 8'd0;
            prev_stall = stall;
            prev_req   = mem_req;
        end
    end

    // ---------------- driver ----------------
    // flags = {sb, sh, sw, lb, lh, lw, lbu, lhu}; ack_delay < 0 means never ack.
    task automatic access(input logic rd, input logic wr, input logic [7:0] flags,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_delay, input logic [31:0] mrd);
        int n;
        d_rd_e = rd;
        d_wr_e = wr;
        {sb, sh, sw, lb, lh, lw, lbu, lhu} = flags;
        addr  = a;
        wdata = wd;
        @(posedge clk); #1;
        d_rd_e = 1'b0;
        d_wr_e = 1'b0;
        {sb, sh, sw, lb, lh, lw, lbu, lhu} = 8'd0;
        if (ack_delay >= 0) begin
            for (int i = 0; i < ack_delay; i++) begin
                @(posedge clk); #1;
            end
            mem_ack   = 1'b1;
            mem_rdata = mrd;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        n = 0;
        while (stall && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_release_bound", 32'(n >= 300), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        d_rd_e = 0; d_wr_e = 0;
        {sb, sh, sw, lb, lh, lw, lbu, lhu} = 8'd0;
        addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pulses", {30'd0, misalign, bus_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // lw 0x100, ack on first REQ cycle
        push_req(1'b0, 4'b1111, 32'h100, 32'h0);
        push_end(1'b0, 8'd2, 32'h8899AABB);
        access(1'b1, 1'b0, 8'b0000_0100, 32'h103 & 32'hFFFF_FFFC, 32'h0, 0, 32'h8899AABB);

        // lb / lbu at 0x103
        push_req(1'b0, 4'b1000, 32'h100, 32'h0);
        push_end(1'b0, 8'd2, 32'hFFFFFF80);
        access(1'b1, 1'b0, 8'b0001_0000, 32'h103, 32'h0, 0, 32'h80FF0000);
        push_req(1'b0, 4'b1000, 32'h100, 32'h0);
        push_end(1'b0, 8'd4, 32'h00000080);
        access(1'b1, 1'b0, 8'b0000_0010, 32'h103, 32'h0, 2, 32'h80FF0000);

        // sh at 0x102: rdata keeps the previous load value
        push_req(1'b1, 4'b1100, 32'h100, 32'hABCDABCD);
        push_end(1'b0, 8'd2, 32'h00000080);
        access(1'b0, 1'b1, 8'b0100_0000, 32'h102, 32'h1234ABCD, 0, 32'hDEADBEEF);

        // misaligned lw
        push_mis(32'h0);
        access(1'b1, 1'b0, 8'b0000_0100, 32'h101, 32'h0, -2, 32'h0);

        // lh upper half / lhu lower half
        push_req(1'b0, 4'b1100, 32'h200, 32'h0);
        push_end(1'b0, 8'd2, 32'hFFFF8001);
        access(1'b1, 1'b0, 8'b0000_1000, 32'h202, 32'h0, 0, 32'h80011234);
        push_req(1'b0, 4'b0011, 32'h200, 32'h0);
        push_end(1'b0, 8'd2, 32'h00001234);
        access(1'b1, 1'b0, 8'b0000_0001, 32'h200, 32'h0, 0, 32'h80011234);

        // sb at 0x201, sw at 0x300
        push_req(1'b1, 4'b0010, 32'h200, 32'h5A5A5A5A);
        push_end(1'b0, 8'd2, 32'h00001234);
        access(1'b0, 1'b1, 8'b1000_0000, 32'h201, 32'h0000005A, 0, 32'h0);
        push_req(1'b1, 4'b1111, 32'h300, 32'hCAFEF00D);
        push_end(1'b0, 8'd3, 32'h00001234);
        access(1'b0, 1'b1, 8'b0010_0000, 32'h300, 32'hCAFEF00D, 1, 32'h0);

        // load a nonzero value, then time out
        push_req(1'b0, 4'b1111, 32'h304, 32'h0);
        push_end(1'b0, 8'd2, 32'h11223344);
        access(1'b1, 1'b0, 8'b0000_0100, 32'h304, 32'h0, 0, 32'h11223344);
        push_req(1'b0, 4'b1111, 32'h400, 32'h0);
        push_end(1'b1, 8'd5, 32'h0);
        access(1'b1, 1'b0, 8'b0000_0100, 32'h400, 32'h0, -1, 32'h0);

        // ack on the last allowed REQ cycle is still a success
        push_req(1'b0, 4'b1111, 32'h404, 32'h0);
        push_end(1'b0, 8'd5, 32'h55667788);
        access(1'b1, 1'b0, 8'b0000_0100, 32'h404, 32'h0, 3, 32'h55667788);

        // read and write together: write wins
        push_req(1'b1, 4'b1111, 32'h500, 32'h0BADF00D);
        push_end(1'b0, 8'd2, 32'h55667788);
        access(1'b1, 1'b1, 8'b0010_0100, 32'h500, 32'h0BADF00D, 0, 32'h0);

        // no size flag: treated as word
        push_req(1'b0, 4'b1111, 32'h600, 32'h0);
        push_end(1'b0, 8'd2, 32'hA5A50F0F);
        access(1'b1, 1'b0, 8'b0000_0000, 32'h600, 32'h0, 0, 32'hA5A50F0F);

        // misaligned sh clears rdata
        push_mis(32'h0);
        access(1'b0, 1'b1, 8'b0100_0000, 32'h203, 32'h0, -2, 32'h0);

        // reset in the middle of REQ
        d_rd_e = 1'b1; lw = 1'b1; addr = 32'h700;
        @(posedge clk); #1;
        check("req_before_reset", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mem_req_async_drop", 32'(mem_req), 32'd0);
        check("stall_in_reset", 32'(stall), 32'd0);
        d_rd_e = 1'b0; lw = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("post_reset_stall", 32'(stall), 32'd0);
            check("post_reset_req", 32'(mem_req), 32'd0);
        end
        push_req(1'b0, 4'b1111, 32'h704, 32'h0);
        push_end(1'b0, 8'd2, 32'h0F1E2D3C);
        access(1'b1, 1'b0, 8'b0000_0100, 32'h704, 32'h0, 0, 32'h0F1E2D3C);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles spent waiting for mem_ack; legal range is 1..255.
REQ-003 Ports SHALL be, one per entry (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- d_rd_e  in  1  load request from decode.
- d_wr_e  in  1  store request from decode.
- sb, sh, sw  in  1 each  store size flags.
- lb, lh, lw, lbu, lhu  in  1 each  load size/sign flags.
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  formatted load result to writeback.
- stall  out  1  hold PC/regfile while high.
- misalign  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on timeout.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address, with addr[1:0] forced to 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  32  memory read word.

Function
REQ-004 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-005 In IDLE, when d_rd_e or d_wr_e is high and the access is aligned, stall SHALL be 1 combinationally in the same cycle, and the next state SHALL be REQ.
REQ-006 On the IDLE to REQ transition, the block SHALL register mem_addr, mem_we, mem_be, mem_wdata, the size and sign, and addr[1:0].
REQ-007 In REQ, mem_req SHALL be 1, stall SHALL be 1, and the registered request fields SHALL be held stable until mem_ack.
REQ-008 In REQ, when mem_ack is high, the block SHALL capture the formatted mem_rdata into rdata (loads only) and the next state SHALL be DONE.
REQ-009 In DONE, stall SHALL be 0, rdata SHALL hold, all inputs SHALL be ignored, and the next state SHALL be IDLE.
- Minimum access latency is therefore 2 stalled cycles plus 1 release cycle.
REQ-010 Byte enables SHALL be:
- sb: 0001 shifted left by addr[1:0].
- sh: 0011 shifted left by {addr[1],0}.
- sw: 1111.
REQ-011 Store data SHALL be replicated: sb = {4{wdata[7:0]}}, sh = {2{wdata[15:0]}}, sw = wdata.
REQ-012 Loads SHALL select the addressed byte or halfword; lb and lh sign-extend, lbu and lhu zero-extend, and lw passes the word through.
REQ-013 Misalignment is defined as (lh | lhu | sh) with addr[0] = 1, or (lw | sw) with addr[1:0] != 00.
- On misalignment: no mem_req, misalign = 1 for one cycle, stall = 0, rdata = 0, and the FSM stays in IDLE.
REQ-014 If both d_rd_e and d_wr_e are high, the write SHALL take priority.
REQ-015 If multiple size flags are high, priority SHALL be word, then half, then byte.
REQ-016 If no size flag is high, the access SHALL be treated as word.
REQ-017 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack.
- When the counter reaches TIMEOUT: bus_err = 1 for one cycle, rdata = 0, and the next state is DONE.
REQ-018 mem_ack SHALL be ignored outside REQ.
REQ-019 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success, with no bus_err.

Reset
REQ-020 While rst_n = 0, the following SHALL reset asynchronously: state = IDLE, mem_req = 0, mem_we = 0, mem_be = 0000, mem_addr = 0, mem_wdata = 0, rdata = 0, counter = 0, misalign = 0, bus_err = 0.
REQ-021 stall SHALL be 0 during reset.
REQ-022 Reset asserted mid-REQ SHALL drop mem_req immediately and abandon the access, with no retry after reset is released.

Structure
REQ-023 Package lsu_pkg SHALL hold the state enum, the size encoding (BYTE/HALF/WORD) and the byte-enable constants.
REQ-024 Load formatting (lane select plus sign/zero extension) SHALL be a combinational sub-module named lsu_load_align.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response):
- lw at addr 0x100, mem_rdata 0x8899AABB, ack on 1st REQ cycle -> mem_be 1111, rdata 0x8899AABB, stall high exactly 2 cycles.
- lb at 0x103 with mem_rdata 0x80FF0000 -> rdata 0xFFFFFF80; lbu at the same address -> rdata 0x00000080.
- sh at 0x102 with wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
- lw at 0x101 -> misalign pulse, no mem_req, stall 0, rdata 0.
- TIMEOUT = 4 and no ack -> bus_err after 4 REQ cycles, rdata 0, FSM returns to IDLE via DONE.
- rst_n low during REQ -> mem_req drops asynchronously; after release, the FSM is in IDLE and stall is 0.
